stage_mem: RTL and testbench
============================

# stage_MEM

Memory-access stage of the 5-stage RISC-V pipeline. Sits directly downstream of the execute stage and consumes the EX/MEM-registered ALU result as the address and the forwarded rs2 value as store data. It contains the byte-enabled synchronous data memory and the MEM/WB pipeline register, and presents the aligned, sign/zero-extended load data to write-back.

## Interface
Parameters:
- REG_WIDTH, `REG_WIDTH (32): datapath width; only 32 is supported, because byte lanes are fixed at 4.
- DMEM_DEPTH, 1024: data memory depth in 32-bit words; must be a power of 2.

Ports:
- clk  in  1  clock; all state is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold MEM/WB and suppress the memory write this cycle.
- flush  in  1  insert a bubble into MEM/WB and suppress the memory write this cycle.
- EX_MEM_alu_out  in  REG_WIDTH  byte address, or the ALU result that passes through.
- EX_MEM_dataB  in  REG_WIDTH  store data (rs2).
- EX_MEM_mem_rw  in  1  1 = store, 0 = load or no access.
- EX_MEM_mem_en  in  1  memory access is valid this cycle.
- EX_MEM_funct3  in  3  width/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- EX_MEM_reg_wen  in  1  register-file write enable.
- EX_MEM_wb_sel  in  2  write-back select: 00 mem, 01 alu, 10 pc+4.
- EX_MEM_rd  in  5  destination register.
- EX_MEM_pc_plus4  in  REG_WIDTH  link value.
- MEM_WB_alu_out  out  REG_WIDTH  registered ALU result.
- MEM_WB_load_data  out  REG_WIDTH  extended load data.
- MEM_WB_pc_plus4  out  REG_WIDTH  registered link value.
- MEM_WB_wb_sel  out  2  registered write-back select.
- MEM_WB_reg_wen  out  1  registered register-file write enable.
- MEM_WB_rd  out  5  registered destination register.
- MEM_WB_misaligned  out  1  registered misaligned-access flag.

## Operation
Address decode:
- word index = EX_MEM_alu_out[log2(DMEM_DEPTH)+1:2]; higher bits are ignored, so addresses wrap modulo 4*DMEM_DEPTH.
- offset = EX_MEM_alu_out[1:0].

Misaligned access:
- Condition: mem_en=1 and either (H/HU with offset[0]=1) or (W with offset!=0).
- On a misaligned store, no byte is written.
- On a misaligned load, MEM_WB_load_data = 0.
- MEM_WB_misaligned = 1. MEM_WB_reg_wen still follows EX_MEM_reg_wen; trap handling is outside this block.

Store (mem_en=1, mem_rw=1, aligned, stall=0, flush=0):
- SB writes lane offset with dataB[7:0].
- SH writes lanes {offset[1],0} and {offset[1],1} with dataB[15:0].
- SW writes all 4 lanes.
- Any other funct3 on a store writes nothing.

Load:
- The memory word is read synchronously whenever mem_en=1 and the register is not stalled.
- offset and funct3 are registered alongside the read word.
- Lane select and extension are combinational after the register: B/H sign-extend, BU/HU zero-extend, W passes through.
- Undefined funct3 yields 0.

MEM/WB register:
- Captures alu_out, pc_plus4, wb_sel, reg_wen, rd, misaligned, offset, funct3 and the read word each cycle.
- stall=1 holds every field, including the read word.
- flush=1 (priority over stall) loads a bubble: reg_wen=0, misaligned=0, all other fields 0.

Reset:
- All MEM/WB fields go to 0, so every output reads 0.
- Memory contents are not reset; reads before the first write are undefined and the bench must not check them.

## Timing
- A store presented in cycle N is written at edge N→N+1.
- A load presented in cycle N has MEM_WB_load_data valid in cycle N+1. Total latency is 1 cycle; the stage is fully pipelined at 1 access per cycle.
- A store in N followed by a load to the same word in N+1 returns the new data. The write completes before the N+1 read edge; no internal bypass is required.
- If reset_n is asserted mid-operation, outputs are 0 immediately (asynchronously). A store whose edge coincides with reset assertion may be lost.
- flush and stall both high: flush wins, and there is no write.

## Structure
- Shared header `risc_v_defines.vh` holds funct3 load/store codes, wb_sel codes and REG_WIDTH.
- One sub-module, data_mem: a byte-enabled synchronous RAM with ports clk, we[3:0], addr, wdata, re, rdata. Its read register is stalled via re.
- Store byte-enable generation, the misalignment check and load extension stay in stage_MEM as combinational blocks.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 next cycle -> load_data 0xDEADBEEF, 1 cycle after the load.
- SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- SH 0x1234 @0x12; LH @0x11 -> misaligned=1, load_data 0, memory unchanged; LHU @0x12 -> 0x00001234.
- Store with stall=1, then flush=1, then both high -> memory unchanged; MEM/WB holds on stall; reg_wen=0 after flush.
- Address 0x1000 with DMEM_DEPTH=1024 -> aliases word 0; SW 0x5 there, then LW @0x0 -> 0x5.
- Assert reset_n mid-stream with reg_wen=1 and rd=7 in MEM/WB -> all outputs 0 immediately; first load after release returns correct data.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage: datapath sizes,
// funct3 load/store codes and write-back select codes.
package stage_mem_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int DMEM_DEPTH = 1024;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  // Halfwords need an even offset, words need offset 0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if ((funct3 == F3_H || funct3 == F3_HU) && offset[0])
      mis = 1'b1;
    if (funct3 == F3_W && offset != 2'b00)
      mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/stage_mem_if.sv
// EX/MEM inputs, pipeline controls and MEM/WB outputs of the memory stage.
// The master side is the surrounding pipeline, the slave side is stage_mem.
interface stage_mem_if;
  import stage_mem_pkg::*;

  logic                 stall;
  logic                 flush;
  logic [REG_WIDTH-1:0] EX_MEM_alu_out;
  logic [REG_WIDTH-1:0] EX_MEM_dataB;
  logic                 EX_MEM_mem_rw;
  logic                 EX_MEM_mem_en;
  logic [2:0]           EX_MEM_funct3;
  logic                 EX_MEM_reg_wen;
  logic [1:0]           EX_MEM_wb_sel;
  logic [4:0]           EX_MEM_rd;
  logic [REG_WIDTH-1:0] EX_MEM_pc_plus4;

  logic [REG_WIDTH-1:0] MEM_WB_alu_out;
  logic [REG_WIDTH-1:0] MEM_WB_load_data;
  logic [REG_WIDTH-1:0] MEM_WB_pc_plus4;
  logic [1:0]           MEM_WB_wb_sel;
  logic                 MEM_WB_reg_wen;
  logic [4:0]           MEM_WB_rd;
  logic                 MEM_WB_misaligned;

  modport master (
    output stall, flush, EX_MEM_alu_out, EX_MEM_dataB, EX_MEM_mem_rw, EX_MEM_mem_en,
           EX_MEM_funct3, EX_MEM_reg_wen, EX_MEM_wb_sel, EX_MEM_rd, EX_MEM_pc_plus4,
    input  MEM_WB_alu_out, MEM_WB_load_data, MEM_WB_pc_plus4, MEM_WB_wb_sel,
           MEM_WB_reg_wen, MEM_WB_rd, MEM_WB_misaligned
  );

  modport slave (
    input  stall, flush, EX_MEM_alu_out, EX_MEM_dataB, EX_MEM_mem_rw, EX_MEM_mem_en,
           EX_MEM_funct3, EX_MEM_reg_wen, EX_MEM_wb_sel, EX_MEM_rd, EX_MEM_pc_plus4,
    output MEM_WB_alu_out, MEM_WB_load_data, MEM_WB_pc_plus4, MEM_WB_wb_sel,
           MEM_WB_reg_wen, MEM_WB_rd, MEM_WB_misaligned
  );

endinterface

// File: rtl/stage_mem_data_mem.sv
// Byte-enabled synchronous data RAM. Contents are never reset; the read
// register only updates when re is high so the pipeline can hold it.
module data_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH];

  // Per-lane write and registered read; a write is visible to a read one edge later.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i])
        mem[addr][i] <= wdata[8*i +: 8];
    end
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: store byte-enable generation, misalignment check,
// the data memory, the MEM/WB register and load lane select/extension.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int DMEM_DEPTH = stage_mem_pkg::DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  stage_mem_if.slave  bus
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [AW-1:0]        word_idx;
  logic [1:0]           offset;
  logic                 misaligned;
  logic                 write_ok;
  logic [3:0]           byte_en;
  logic [31:0]          store_data;
  logic [31:0]          read_word;
  logic                 mem_re;

  logic [REG_WIDTH-1:0] wb_alu_out;
  logic [REG_WIDTH-1:0] wb_pc_plus4;
  logic [1:0]           wb_sel;
  logic                 wb_reg_wen;
  logic [4:0]           wb_rd;
  logic                 wb_misaligned;
  logic [1:0]           wb_offset;
  logic [2:0]           wb_funct3;
  logic                 wb_load_valid;
  logic [REG_WIDTH-1:0] load_data;

  assign word_idx   = bus.EX_MEM_alu_out[AW+1:2];
  assign offset     = bus.EX_MEM_alu_out[1:0];
  assign misaligned = bus.EX_MEM_mem_en && is_misaligned(bus.EX_MEM_funct3, offset);
  assign write_ok   = bus.EX_MEM_mem_en && bus.EX_MEM_mem_rw && !misaligned &&
                      !bus.stall && !bus.flush;
  assign mem_re     = bus.EX_MEM_mem_en && !bus.stall;

  // Store lane enables and lane-replicated write data from funct3 and offset.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = bus.EX_MEM_dataB;
    case (bus.EX_MEM_funct3)
      F3_B: begin
        store_data = {4{bus.EX_MEM_dataB[7:0]}};
        if (write_ok) byte_en = 4'b0001 << offset;
      end
      F3_H: begin
        store_data = {2{bus.EX_MEM_dataB[15:0]}};
        if (write_ok) byte_en = offset[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        if (write_ok) byte_en = 4'b1111;
      end
      default: byte_en = 4'b0000;
    endcase
  end

  data_mem #(.DEPTH(DMEM_DEPTH), .AW(AW)) u_data_mem (
    .clk   (clk),
    .we    (byte_en),
    .addr  (word_idx),
    .wdata (store_data),
    .re    (mem_re),
    .rdata (read_word)
  );

  // MEM/WB register: flush inserts a bubble, stall holds, otherwise capture.
  // load_valid gates the read word so bubbles, stores and misaligned loads read 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_alu_out    <= '0;
      wb_pc_plus4   <= '0;
      wb_sel        <= '0;
      wb_reg_wen    <= 1'b0;
      wb_rd         <= '0;
      wb_misaligned <= 1'b0;
      wb_offset     <= '0;
      wb_funct3     <= '0;
      wb_load_valid <= 1'b0;
    end else if (bus.flush) begin
      wb_alu_out    <= '0;
      wb_pc_plus4   <= '0;
      wb_sel        <= '0;
      wb_reg_wen    <= 1'b0;
      wb_rd         <= '0;
      wb_misaligned <= 1'b0;
      wb_offset     <= '0;
      wb_funct3     <= '0;
      wb_load_valid <= 1'b0;
    end else if (!bus.stall) begin
      wb_alu_out    <= bus.EX_MEM_alu_out;
      wb_pc_plus4   <= bus.EX_MEM_pc_plus4;
      wb_sel        <= bus.EX_MEM_wb_sel;
      wb_reg_wen    <= bus.EX_MEM_reg_wen;
      wb_rd         <= bus.EX_MEM_rd;
      wb_misaligned <= misaligned;
      wb_offset     <= offset;
      wb_funct3     <= bus.EX_MEM_funct3;
      wb_load_valid <= bus.EX_MEM_mem_en && !bus.EX_MEM_mem_rw && !misaligned;
    end
  end

  // Lane select and sign/zero extension of the registered read word.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b    = read_word[8*wb_offset +: 8];
    lane_h    = wb_offset[1] ? read_word[31:16] : read_word[15:0];
    load_data = '0;
    if (wb_load_valid) begin
      case (wb_funct3)
        F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
        F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
        F3_W:    load_data = read_word;
        F3_BU:   load_data = {24'h0, lane_b};
        F3_HU:   load_data = {16'h0, lane_h};
        default: load_data = '0;
      endcase
    end
  end

  assign bus.MEM_WB_alu_out    = wb_alu_out;
  assign bus.MEM_WB_load_data  = load_data;
  assign bus.MEM_WB_pc_plus4   = wb_pc_plus4;
  assign bus.MEM_WB_wb_sel     = wb_sel;
  assign bus.MEM_WB_reg_wen    = wb_reg_wen;
  assign bus.MEM_WB_rd         = wb_rd;
  assign bus.MEM_WB_misaligned = wb_misaligned;

endmodule

// File: tb/tb_stage_mem.sv
// Randomized and directed bench for stage_mem against a byte-array memory model.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  stage_mem_if bus();

  stage_mem dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem_model [4096];
  logic [31:0] exp_alu, exp_ld, exp_pc;
  logic [1:0]  exp_sel;
  logic        exp_wen, exp_mis;
  logic [4:0]  exp_rd;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
    int off;
    off = int'(addr[1:0]);
    if ((f3 == 3'b001 || f3 == 3'b101) && (off % 2 == 1)) return 1'b1;
    if (f3 == 3'b010 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr[11:0]);
    case (f3)
      3'b000: begin b = mem_model[a]; return {{24{b[7]}}, b}; end
      3'b100: return {24'h0, mem_model[a]};
      3'b001: begin h = {mem_model[a+1], mem_model[a]}; return {{16{h[15]}}, h}; end
      3'b101: return {16'h0, mem_model[a+1], mem_model[a]};
      3'b010: return {mem_model[a+3], mem_model[a+2], mem_model[a+1], mem_model[a]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".alu"},  bus.MEM_WB_alu_out, exp_alu);
    checkOutput({tag, ".ld"},   bus.MEM_WB_load_data, exp_ld);
    checkOutput({tag, ".pc"},   bus.MEM_WB_pc_plus4, exp_pc);
    checkOutput({tag, ".sel"},  {30'h0, bus.MEM_WB_wb_sel}, {30'h0, exp_sel});
    checkOutput({tag, ".wen"},  {31'h0, bus.MEM_WB_reg_wen}, {31'h0, exp_wen});
    checkOutput({tag, ".rd"},   {27'h0, bus.MEM_WB_rd}, {27'h0, exp_rd});
    checkOutput({tag, ".mis"},  {31'h0, bus.MEM_WB_misaligned}, {31'h0, exp_mis});
  endtask

  task automatic clearExpected();
    exp_alu = '0; exp_ld = '0; exp_pc = '0; exp_sel = '0;
    exp_wen = 1'b0; exp_rd = '0; exp_mis = 1'b0;
  endtask

  // Drives one cycle, advances the model, then checks MEM/WB after the edge.
  task automatic applyStimulus(input logic en, input logic rw, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic st, input logic fl, input logic wen,
                               input logic [1:0] sel, input logic [4:0] rd,
                               input logic [31:0] pc, input string tag);
    logic mis;
    int   a;
    bus.EX_MEM_mem_en   = en;
    bus.EX_MEM_mem_rw   = rw;
    bus.EX_MEM_funct3   = f3;
    bus.EX_MEM_alu_out  = addr;
    bus.EX_MEM_dataB    = data;
    bus.stall           = st;
    bus.flush           = fl;
    bus.EX_MEM_reg_wen  = wen;
    bus.EX_MEM_wb_sel   = sel;
    bus.EX_MEM_rd       = rd;
    bus.EX_MEM_pc_plus4 = pc;
    mis = en && model_mis(f3, addr);
    if (fl) begin
      clearExpected();
    end else if (!st) begin
      exp_alu = addr; exp_pc = pc; exp_sel = sel; exp_wen = wen; exp_rd = rd; exp_mis = mis;
      exp_ld  = (en && !rw && !mis) ? ref_load(addr, f3) : 32'h0;
    end
    if (en && rw && !mis && !st && !fl) begin
      a = int'(addr[11:0]);
      case (f3)
        3'b000: mem_model[a] = data[7:0];
        3'b001: begin mem_model[a] = data[7:0]; mem_model[a+1] = data[15:8]; end
        3'b010: begin
          mem_model[a]   = data[7:0];   mem_model[a+1] = data[15:8];
          mem_model[a+2] = data[23:16]; mem_model[a+3] = data[31:24];
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, tag);
  endtask

  initial begin
    logic [2:0] f3_list [7];
    f3_list = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};

    reset_n = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.EX_MEM_mem_en = 1'b0; bus.EX_MEM_mem_rw = 1'b0; bus.EX_MEM_funct3 = '0;
    bus.EX_MEM_alu_out = '0; bus.EX_MEM_dataB = '0; bus.EX_MEM_reg_wen = 1'b0;
    bus.EX_MEM_wb_sel = '0; bus.EX_MEM_rd = '0; bus.EX_MEM_pc_plus4 = '0;
    clearExpected();
    #22;
    checkAll("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill every word so later loads never see undefined contents.
    for (int i = 0; i < 1024; i++)
      applyStimulus(1'b1, 1'b1, 3'b010, i * 4, $urandom, 1'b0, 1'b0, 1'b0, 2'b01,
                    5'(i), 32'(i * 4 + 4), "init");

    applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2'b01, 5'd0, 32'h104, "sw");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd1, 32'h108, "lw");
    checkOutput("lw_deadbeef", bus.MEM_WB_load_data, 32'hDEADBEEF);

    applyStimulus(1'b1, 1'b1, 3'b000, 32'h13, 32'h00000080, 1'b0, 1'b0, 1'b0, 2'b01, 5'd0, 32'h10C, "sb");
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd2, 32'h110, "lb");
    checkOutput("lb_sext", bus.MEM_WB_load_data, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd2, 32'h114, "lbu");
    checkOutput("lbu_zext", bus.MEM_WB_load_data, 32'h00000080);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd2, 32'h118, "lw2");
    checkOutput("lw_after_sb", bus.MEM_WB_load_data, 32'h80ADBEEF);

    applyStimulus(1'b1, 1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0, 1'b0, 1'b0, 2'b01, 5'd0, 32'h11C, "sh");
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd4, 32'h120, "lh_mis");
    checkOutput("lh_mis_flag", {31'h0, bus.MEM_WB_misaligned}, 32'h1);
    checkOutput("lh_mis_data", bus.MEM_WB_load_data, 32'h0);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd4, 32'h124, "lhu");
    checkOutput("lhu_data", bus.MEM_WB_load_data, 32'h00001234);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd3, 32'h128, "lw3");
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 2'b01, 5'd9, 32'h12C, "sw_stall");
    checkOutput("stall_hold_ld", bus.MEM_WB_load_data, 32'h1234BEEF);
    checkOutput("stall_hold_rd", {27'h0, bus.MEM_WB_rd}, 32'd3);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hAAAA5555, 1'b0, 1'b1, 1'b1, 2'b01, 5'd9, 32'h130, "sw_flush");
    checkOutput("flush_wen", {31'h0, bus.MEM_WB_reg_wen}, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h10, 32'hAAAA5555, 1'b1, 1'b1, 1'b1, 2'b01, 5'd9, 32'h134, "sw_both");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd3, 32'h138, "lw4");
    checkOutput("mem_unchanged", bus.MEM_WB_load_data, 32'h1234BEEF);

    applyStimulus(1'b1, 1'b1, 3'b010, 32'h1000, 32'h5, 1'b0, 1'b0, 1'b0, 2'b01, 5'd0, 32'h13C, "sw_alias");
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd5, 32'h140, "lw_alias");
    checkOutput("alias_word0", bus.MEM_WB_load_data, 32'h5);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd7, 32'h144, "pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    clearExpected();
    checkAll("async_reset");
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd7, 32'h148, "post_reset");
    checkOutput("post_reset_ld", bus.MEM_WB_load_data, 32'h1234BEEF);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] addr;
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFF_F000);
      applyStimulus(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)),
                    f3_list[$urandom_range(0, 6)], addr, $urandom,
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    5'($urandom_range(0, 31)), $urandom, "rand");
    end
    idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
